// File: rtl/pila_retorno.sv
// pila_retorno: return-address LIFO for the monocycle CPU.
// Saves PC+1 on call (push) and presents the return address on dout
// combinationally so a return (pop) can use it in the same cycle.
// Optional sticky overflow/underflow flags are built when the macro
// PILA_ERR_EN is defined; without it the ovf/unf ports do not exist.
module pila_retorno #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
`ifdef PILA_ERR_EN
    ,
    output logic                     ovf,
    output logic                     unf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Occupancy: 0..DEPTH, top entry lives at sp_q-1.
    logic [CW-1:0]    sp_q;
    logic [CW-1:0]    sp_d;
    logic [CW-1:0]    sp_m1;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             wr_en;
    logic             is_empty;
    logic             is_full;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == CW'(DEPTH));
    assign sp_m1    = sp_q - CW'(1);
    assign top_idx  = sp_m1[AW-1:0];

    // Next occupancy and write port; push+pop on a non-empty stack overwrites the top.
    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = sp_q[AW-1:0];
        if (push && pop) begin
            wr_en = 1'b1;
            if (is_empty) begin
                sp_d = sp_q + CW'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            if (!is_full) begin
                wr_en = 1'b1;
                sp_d  = sp_q + CW'(1);
            end
        end else if (pop) begin
            if (!is_empty) begin
                sp_d = sp_m1;
            end
        end
        // A strobe coinciding with reset is discarded, including its array write.
        if (reset) begin
            wr_en = 1'b0;
        end
    end

    // Occupancy register, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents survive reset since sp_q hides them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign dout  = is_empty ? '0 : mem_q[top_idx];
    assign empty = is_empty;
    assign full  = is_full;
    assign count = sp_q;

`ifdef PILA_ERR_EN
    logic ovf_q;
    logic ovf_d;
    logic unf_q;
    logic unf_d;

    // Sticky error conditions: ignored push when full, ignored pop when empty.
    always_comb begin
        ovf_d = ovf_q | (push & ~pop & is_full);
        unf_d = unf_q | (pop & ~push & is_empty);
    end

    // Error flag registers, held until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`endif

endmodule

// File: tb/tb_pila_retorno.sv
// Testbench for pila_retorno: directed vectors, expected states queued
// by the stimulus process and checked by a separate monitor process.
module tb_pila_retorno;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] din;
    logic [9:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
`ifdef PILA_ERR_EN
    logic       ovf;
    logic       unf;
`endif

    pila_retorno #(.WIDTH(10), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count)
`ifdef PILA_ERR_EN
        ,
        .ovf   (ovf),
        .unf   (unf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [9:0] dout;
        int         count;
        bit         empty;
        bit         full;
        bit         ovf;
        bit         unf;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic cmp(string tag, string fld, int got, int expv);
        n_total++;
        if (got == expv) n_pass++;
        else $display("FAIL %s %s got=0x%0h exp=0x%0h", tag, fld, got, expv);
    endtask

    // Monitor: drains the scoreboard whenever the stimulus marks a sample point.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.tag, "dout",  int'(dout),  int'(e.dout));
                cmp(e.tag, "count", int'(count), e.count);
                cmp(e.tag, "empty", int'(empty), int'(e.empty));
                cmp(e.tag, "full",  int'(full),  int'(e.full));
`ifdef PILA_ERR_EN
                cmp(e.tag, "ovf",   int'(ovf),   int'(e.ovf));
                cmp(e.tag, "unf",   int'(unf),   int'(e.unf));
`endif
                $display("chk %s: dout=0x%03h count=%0d empty=%0b full=%0b",
                         e.tag, dout, count, empty, full);
            end
        end
    end

    task automatic expect_st(string tag, logic [9:0] d, int c, bit e, bit f, bit o, bit u);
        exp_t x;
        x.tag = tag; x.dout = d; x.count = c; x.empty = e; x.full = f; x.ovf = o; x.unf = u;
        sb.push_back(x);
        -> chk_ev;
        #0;
    endtask

    // Apply strobes at the falling edge, hold across one rising edge, sample 1ns later.
    task automatic set_in(bit p, bit q, logic [9:0] d);
        @(negedge clk);
        push = p; pop = q; din = d;
        #1;
    endtask

    task automatic finish_cyc();
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic cyc(bit p, bit q, logic [9:0] d);
        set_in(p, q, d);
        finish_cyc();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
        #12;
        expect_st("reset", 10'h000, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic push/pop
        cyc(1, 0, 10'h005);
        expect_st("push5", 10'h005, 1, 0, 0, 0, 0);
        cyc(1, 0, 10'h006);
        cyc(1, 0, 10'h007);
        expect_st("push7", 10'h007, 3, 0, 0, 0, 0);
        cyc(0, 1, 10'h000);
        expect_st("pop1", 10'h006, 2, 0, 0, 0, 0);
        cyc(0, 1, 10'h000);
        expect_st("pop2", 10'h005, 1, 0, 0, 0, 0);
        cyc(0, 1, 10'h000);
        expect_st("pop3", 10'h000, 0, 1, 0, 0, 0);

        // Fill and overflow
        for (int i = 0; i < 16; i++) cyc(1, 0, 10'(10'h100 + i));
        expect_st("fill", 10'h10F, 16, 0, 1, 0, 0);
        cyc(1, 0, 10'h3FF);
        expect_st("ovf_push", 10'h10F, 16, 0, 1, 1, 0);
        cyc(0, 1, 10'h000);
        expect_st("pop_full", 10'h10E, 15, 0, 0, 1, 0);
        cyc(1, 0, 10'h10F);
        expect_st("refill", 10'h10F, 16, 0, 1, 1, 0);
        cyc(1, 1, 10'h2AA);
        expect_st("repl_full", 10'h2AA, 16, 0, 1, 1, 0);

        // Underflow
        do_reset();
        expect_st("rst2", 10'h000, 0, 1, 0, 0, 0);
        cyc(0, 1, 10'h000);
        expect_st("unf_pop", 10'h000, 0, 1, 0, 0, 1);
        cyc(1, 0, 10'h012);
        expect_st("push12", 10'h012, 1, 0, 0, 0, 1);
        cyc(0, 1, 10'h000);
        expect_st("pop12", 10'h000, 0, 1, 0, 0, 1);

        // Simultaneous push/pop
        do_reset();
        cyc(1, 0, 10'h020);
        cyc(1, 0, 10'h021);
        expect_st("push21", 10'h021, 2, 0, 0, 0, 0);
        set_in(1, 1, 10'h0AA);
        expect_st("pp_before", 10'h021, 2, 0, 0, 0, 0);
        finish_cyc();
        expect_st("pp_after", 10'h0AA, 2, 0, 0, 0, 0);
        cyc(0, 1, 10'h000);
        expect_st("pp_pop1", 10'h020, 1, 0, 0, 0, 0);
        cyc(0, 1, 10'h000);
        cyc(1, 1, 10'h0BB);
        expect_st("pp_empty", 10'h0BB, 1, 0, 0, 0, 0);
        cyc(0, 1, 10'h000);

        // Asynchronous reset between edges
        cyc(1, 0, 10'h031);
        cyc(1, 0, 10'h032);
        cyc(1, 0, 10'h033);
        expect_st("pre_arst", 10'h033, 3, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        expect_st("arst_now", 10'h000, 0, 1, 0, 0, 0);
        #1;
        reset = 1'b0;
        cyc(1, 0, 10'h001);
        expect_st("post_arst", 10'h001, 1, 0, 0, 0, 0);
        cyc(0, 1, 10'h000);

        // Nested calls: A, B, ret, C, ret, ret
        cyc(1, 0, 10'h0A1);
        cyc(1, 0, 10'h0B2);
        set_in(0, 1, 10'h000);
        expect_st("ret_B", 10'h0B2, 2, 0, 0, 0, 0);
        finish_cyc();
        cyc(1, 0, 10'h0C3);
        set_in(0, 1, 10'h000);
        expect_st("ret_C", 10'h0C3, 2, 0, 0, 0, 0);
        finish_cyc();
        set_in(0, 1, 10'h000);
        expect_st("ret_A", 10'h0A1, 1, 0, 0, 0, 0);
        finish_cyc();
        expect_st("nest_end", 10'h000, 0, 1, 0, 0, 0);

        #5;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pila_retorno.md
# pila_retorno

Return-address stack for the monocycle CPU. It sits directly downstream of the control unit and is driven by that unit's `push`/`pop` strobes. It saves PC+1 on subroutine call and supplies the return address to the PC mux on return, with `s_stack`=1 selecting `dout`. The stack is a synchronous-write, combinational-read LIFO with occupancy tracking and optional sticky error flags.

## Interface
Parameters:
- `WIDTH`, 10, bits per entry; matches the PC width.
- `DEPTH`, 16, number of entries; must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1, single system clock; all state updates on the rising edge.
- `reset`, input, 1, asynchronous, active-high; clears all state immediately.
- `push`, input, 1, write `din` onto the stack at the next edge.
- `pop`, input, 1, remove the top entry at the next edge.
- `din`, input, WIDTH, return address to save (PC+1).
- `dout`, output, WIDTH, current top entry, combinational; 0 when empty.
- `empty`, output, 1, occupancy = 0.
- `full`, output, 1, occupancy = DEPTH.
- `count`, output, $clog2(DEPTH)+1, current occupancy.
- `ovf`, output, 1, sticky overflow flag; present only with `PILA_ERR_EN`.
- `unf`, output, 1, sticky underflow flag; present only with `PILA_ERR_EN`.

## Operation
- Storage is a DEPTH×WIDTH register array plus occupancy counter `sp` (0..DEPTH). The top entry is `mem[sp-1]`.
- Reset values:
  - `sp`=0, `count`=0, `empty`=1, `full`=0, `dout`=0, `ovf`=0, `unf`=0.
  - Array contents are not cleared.
- `dout` is a pure function of the current state: `mem[sp-1]` when `sp`>0, else 0. A pop in the same cycle therefore sees the return address before the edge, as the monocycle datapath requires.
- Push only, not full: `mem[sp]`←`din`, `sp`←`sp`+1.
- Pop only, not empty: `sp`←`sp`−1. The array is unchanged.
- Push and pop together, not empty: top replaced (`mem[sp-1]`←`din`), `sp` unchanged. `dout` shows the old top during that cycle.
- Push and pop together, empty: treated as push only (`mem[0]`←`din`, `sp`←1). No underflow is flagged.
- Push when full (pop low): ignored. `sp` and the array are unchanged, and the overflow condition is raised.
- Pop when empty (push low): ignored. `sp` stays 0, `dout` stays 0, and the underflow condition is raised.
- `count` never exceeds DEPTH and never wraps.

## Timing
- The write, the `sp` update and the flag updates all occur on the same rising edge that samples `push`/`pop`.
- Latency:
  - `dout`, `empty`, `full` and `count` reflect a push/pop one edge after it is sampled.
  - `dout` reflects array writes combinationally after that edge.
- There is no handshake or backpressure. Strobes are single-cycle qualifiers sampled every edge. Holding a strobe high for N cycles performs N operations.
- Reset asserted mid-operation: all state is cleared asynchronously and any strobe pending on that edge is lost. Operation resumes on the first edge after `reset` deasserts.

## Configuration
- Macro: `PILA_ERR_EN`.
- Defined:
  - `ovf` sets on an edge where push is ignored because the stack is full.
  - `unf` sets on an edge where pop is ignored because the stack is empty.
  - Both are sticky until `reset`.
- Undefined:
  - The `ovf`/`unf` ports and their registers are not generated.
  - Ignored push/pop behave identically but are silent.

## Test plan
- Reset → push 0x005, 0x006, 0x007 on consecutive cycles → `count`=3, `dout`=0x007. Then pop ×3 → `dout` sequence 0x006, 0x005, 0, and `empty`=1.
- Fill with 16 pushes of 0x100+i → `full`=1, `dout`=0x10F. A 17th push of 0x3FF → `count`=16, `dout`=0x10F, `ovf`=1 (with `PILA_ERR_EN`).
- Pop while empty → `count`=0, `dout`=0, `unf`=1 (with `PILA_ERR_EN`), no flag port without the macro. Then push 0x012 → `dout`=0x012 and `unf` stays 1.
- Stack holding 0x020, 0x021 + simultaneous push 0x0AA/pop → `dout`=0x021 during that cycle, then `dout`=0x0AA with `count`=2. Simultaneous push 0x0BB/pop on an empty stack → `count`=1, `dout`=0x0BB.
- Push 3 entries, then assert `reset` asynchronously between edges → `count`=0, `empty`=1 and `dout`=0 immediately, without waiting for an edge. First push of 0x001 after deassertion → `dout`=0x001.
- Nested call pattern: push A, push B, pop, push C, pop, pop → popped values in order B, C, A, with `empty`=1 at the end.
